// File: rtl/coin_pkg.sv
// =============================================================================
// coin_pkg : shared coin types, FSM states and counter width for coin sensing
// Revision : 1.0
// =============================================================================
`default_nettype none

package coin_pkg;

  localparam int COUNT_W       = 21;
  localparam int NICKEL_CENTS  = 5;
  localparam int DIME_CENTS    = 10;
  localparam int QUARTER_CENTS = 25;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coin_t;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEASURE  = 2'd2
  } coin_state_t;

  function automatic int coin_cents(input coin_t c);
    case (c)
      COIN_NICKEL:  return NICKEL_CENTS;
      COIN_DIME:    return DIME_CENTS;
      COIN_QUARTER: return QUARTER_CENTS;
      default:      return 0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// =============================================================================
// sync_2ff : two-flop synchroniser with a configurable reset value
// Revision : 1.0
// =============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
    end
  end

  assign o_q = r_sync2;

endmodule

`default_nettype wire

// File: rtl/coin_classifier.sv
// =============================================================================
// coin_classifier : measures coin sensor pulse widths, classifies coins, flags jams
// Revision : 1.0
// =============================================================================
`default_nettype none

module coin_classifier
  import coin_pkg::*;
#(
  parameter logic [COUNT_W-1:0] DIME_MIN    = 21'd400000,
  parameter logic [COUNT_W-1:0] DIME_MAX    = 21'd600000,
  parameter logic [COUNT_W-1:0] NICKEL_MIN  = 21'd800000,
  parameter logic [COUNT_W-1:0] NICKEL_MAX  = 21'd1000000,
  parameter logic [COUNT_W-1:0] QUARTER_MIN = 21'd1200000,
  parameter logic [COUNT_W-1:0] QUARTER_MAX = 21'd1400000,
  parameter logic [COUNT_W-1:0] GLITCH_MAX  = 21'd1,
  parameter logic [COUNT_W-1:0] JAM_LIMIT   = 21'd2000000
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  coinSensor,
  output logic  coinValid,
  output coin_t coinType,
  output logic  coinReject,
  output logic  jam
);

  if (!(GLITCH_MAX < DIME_MIN && DIME_MIN <= DIME_MAX && DIME_MAX < NICKEL_MIN &&
        NICKEL_MIN <= NICKEL_MAX && NICKEL_MAX < QUARTER_MIN &&
        QUARTER_MIN <= QUARTER_MAX && QUARTER_MAX < JAM_LIMIT)) begin : g_param_check
    $fatal(1, "coin_classifier: pulse width thresholds are not strictly ordered");
  end

  // Sensor is treated as high out of reset so a coin already in the slot is ignored.
  logic w_sensor;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (reset),
    .i_d (coinSensor),
    .o_q (w_sensor)
  );

  coin_state_t        r_state;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_inc;
  logic               r_valid;
  coin_t              r_type;
  logic               r_reject;
  logic               r_jam;

  logic  w_valid;
  logic  w_reject;
  coin_t w_type;

  assign w_count_inc = (&r_count) ? r_count : r_count + COUNT_W'(1);

  always_comb begin
    w_valid  = 1'b0;
    w_reject = 1'b0;
    w_type   = COIN_NONE;
    if (r_count >= DIME_MIN && r_count <= DIME_MAX) begin
      w_valid = 1'b1;
      w_type  = COIN_DIME;
    end else if (r_count >= NICKEL_MIN && r_count <= NICKEL_MAX) begin
      w_valid = 1'b1;
      w_type  = COIN_NICKEL;
    end else if (r_count >= QUARTER_MIN && r_count <= QUARTER_MAX) begin
      w_valid = 1'b1;
      w_type  = COIN_QUARTER;
    end else if (r_count > GLITCH_MAX) begin
      w_reject = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= WAIT_LOW;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_type   <= COIN_NONE;
      r_reject <= 1'b0;
      r_jam    <= 1'b0;
    end else begin
      r_valid  <= 1'b0;
      r_type   <= COIN_NONE;
      r_reject <= 1'b0;
      case (r_state)
        WAIT_LOW: begin
          if (!w_sensor) r_state <= IDLE;
        end
        IDLE: begin
          if (w_sensor) begin
            r_state <= MEASURE;
            r_count <= COUNT_W'(1);
          end
        end
        MEASURE: begin
          if (w_sensor) begin
            r_count <= w_count_inc;
            r_jam   <= (w_count_inc >= JAM_LIMIT);
          end else begin
            // Falling edge of the pulse: publish the verdict for the completed width.
            r_valid  <= w_valid;
            r_type   <= w_type;
            r_reject <= w_reject;
            r_jam    <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= WAIT_LOW;
      endcase
    end
  end

  assign coinValid  = r_valid;
  assign coinType   = r_type;
  assign coinReject = r_reject;
  assign jam        = r_jam;

endmodule

`default_nettype wire

// File: tb/tb_coin_classifier.sv
// =============================================================================
// tb_coin_classifier : scoreboard bench for coin_classifier with short thresholds
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_coin_classifier;
  import coin_pkg::*;

  localparam logic [20:0] C_DIME_MIN    = 21'd2;
  localparam logic [20:0] C_DIME_MAX    = 21'd4;
  localparam logic [20:0] C_NICKEL_MIN  = 21'd6;
  localparam logic [20:0] C_NICKEL_MAX  = 21'd8;
  localparam logic [20:0] C_QUARTER_MIN = 21'd10;
  localparam logic [20:0] C_QUARTER_MAX = 21'd12;
  localparam logic [20:0] C_GLITCH_MAX  = 21'd1;
  localparam logic [20:0] C_JAM_LIMIT   = 21'd20;

  logic  clk = 1'b0;
  logic  reset;
  logic  coinSensor;
  logic  coinValid;
  coin_t coinType;
  logic  coinReject;
  logic  jam;

  int n_checks = 0;
  int n_errors = 0;

  // Entry encoding: {reject, coin_t}
  logic [2:0] sb[$];
  logic [2:0] r_obs;
  logic [2:0] r_exp;

  coin_classifier #(
    .DIME_MIN    (C_DIME_MIN),
    .DIME_MAX    (C_DIME_MAX),
    .NICKEL_MIN  (C_NICKEL_MIN),
    .NICKEL_MAX  (C_NICKEL_MAX),
    .QUARTER_MIN (C_QUARTER_MIN),
    .QUARTER_MAX (C_QUARTER_MAX),
    .GLITCH_MAX  (C_GLITCH_MAX),
    .JAM_LIMIT   (C_JAM_LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .coinSensor (coinSensor),
    .coinValid  (coinValid),
    .coinType   (coinType),
    .coinReject (coinReject),
    .jam        (jam)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] expect_of(input int w);
    if (w >= int'(C_DIME_MIN) && w <= int'(C_DIME_MAX))       return {1'b0, COIN_DIME};
    if (w >= int'(C_NICKEL_MIN) && w <= int'(C_NICKEL_MAX))   return {1'b0, COIN_NICKEL};
    if (w >= int'(C_QUARTER_MIN) && w <= int'(C_QUARTER_MAX)) return {1'b0, COIN_QUARTER};
    if (w > int'(C_GLITCH_MAX))                               return {1'b1, COIN_NONE};
    return 3'b000;
  endfunction

  task automatic pulse(input int n, input int gap);
    logic [2:0] e;
    e = expect_of(n);
    if (e != 3'b000) sb.push_back(e);
    coinSensor = 1'b1;
    repeat (n) @(negedge clk);
    coinSensor = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (coinValid || coinReject) begin
      check_eq("both_strobes", 32'(coinValid & coinReject), 32'd0);
      r_obs = {coinReject, coinType};
      r_exp = (sb.size() != 0) ? sb.pop_front() : 3'b111;
      check_eq("strobe", 32'(r_obs), 32'(r_exp));
    end else begin
      check_eq("type_idle", 32'(coinType), 32'(COIN_NONE));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int widths2[6] = '{2, 4, 6, 8, 10, 12};
    int widths3[4] = '{5, 9, 13, 1};

    reset      = 1'b1;
    coinSensor = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid",  32'(coinValid),  32'd0);
    check_eq("rst_type",   32'(coinType),   32'(COIN_NONE));
    check_eq("rst_reject", 32'(coinReject), 32'd0);
    check_eq("rst_jam",    32'(jam),        32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Dime of width 3 with strobe latency measured from the release
    sb.push_back(expect_of(3));
    coinSensor = 1'b1;
    repeat (3) @(negedge clk);
    coinSensor = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("latency_early", 32'(coinValid), 32'd0);
    @(negedge clk);
    check_eq("latency", 32'(coinValid), 32'd1);
    repeat (4) @(negedge clk);

    foreach (widths2[i]) pulse(widths2[i], 5);
    foreach (widths3[i]) pulse(widths3[i], 5);

    // Stuck sensor: jam rises when the count reaches 20 and drops on release
    sb.push_back(expect_of(25));
    coinSensor = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 21) check_eq("jam_before", 32'(jam), 32'd0);
      if (i == 22) check_eq("jam_rise",   32'(jam), 32'd1);
    end
    coinSensor = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("jam_hold", 32'(jam), 32'd1);
    @(negedge clk);
    check_eq("jam_fall", 32'(jam), 32'd0);
    repeat (4) @(negedge clk);

    // Reset in the middle of a pulse: that pulse is never reported
    coinSensor = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_valid",  32'(coinValid),  32'd0);
    check_eq("midrst_reject", 32'(coinReject), 32'd0);
    check_eq("midrst_jam",    32'(jam),        32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    coinSensor = 1'b0;
    repeat (6) @(negedge clk);
    pulse(7, 5);

    // Back-to-back pulses separated by a single low cycle
    sb.push_back(expect_of(3));
    sb.push_back(expect_of(11));
    coinSensor = 1'b1;
    repeat (3) @(negedge clk);
    coinSensor = 1'b0;
    @(negedge clk);
    coinSensor = 1'b1;
    repeat (11) @(negedge clk);
    coinSensor = 1'b0;
    repeat (8) @(negedge clk);

    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
